hash_msg_streamer: RTL and testbench

HASH_MSG_STREAMER -- requirements
Module: hash_msg_streamer

---
 rtl/hash_msg_streamer_pkg.sv | 24 ++
 rtl/hash_msg_fifo.sv | 50 +++++
 rtl/hash_msg_streamer.sv | 167 ++++++++++++++++
 tb/tb_hash_msg_streamer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hash_msg_streamer_pkg.sv
// Shared definitions for the hash message streamer: parameter defaults,
// FSM state encoding and the nibble-to-ASCII helper used for the digest.
package hash_msg_streamer_pkg;

  localparam int DEPTH_DEF = 16;
  localparam int GAP_W_DEF = 3;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    GAP,
    WAIT_DIG,
    HEX,
    FIN
  } state_t;

  // Lowercase hex: 0-9 -> 0x30-0x39, a-f -> 0x61-0x66
  function automatic logic [7:0] nib2asc(input logic [3:0] n);
    logic [7:0] v;
    v = {4'h0, n};
    return (n < 4'd10) ? (8'h30 + v) : (8'h57 + v);
  endfunction

endpackage

// File: rtl/hash_msg_fifo.sv
// Synchronous byte FIFO holding the message before it is streamed out.
// Ports:
//   clk, rst_n        clock, async active-low reset (empties the FIFO)
//   wr_en, wr_data    push a byte (ignored when full)
//   rd_en             pop the oldest byte (ignored when empty)
//   rd_data           oldest byte, valid whenever !empty (show-ahead)
//   full, empty       occupancy flags
//   count             number of stored bytes, 0..DEPTH
module hash_msg_fifo
  import hash_msg_streamer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (rd_en && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/hash_msg_streamer.sv
// Buffers an ASCII message, streams it byte by byte to a hash core with a
// programmable idle gap, waits for the digest and emits it as 16 lowercase
// hex characters over a valid/ready handshake.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   wr_valid/wr_data/wr_ready   host byte write (accepted only in IDLE)
//   start, c_init, gap      begin hashing; c_init/gap sampled on accepted start
//   busy                    high from accepted start until back in IDLE
//   M_valid, M, C_in        byte strobe, byte and init value to the hash core
//   hash_ready, digest_out  digest from the hash core
//   hex_valid/hex_char/hex_ready   hex digit stream to the sink
//   done                    one-cycle pulse after the last digit is taken
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | accept host bytes, wait for start with a non-empty buffer
// SEND     | strobe oldest byte to the core and pop it
// GAP      | idle cycles between bytes (down-counter, ends at count 1)
// WAIT_DIG | wait for hash_ready, latch digest
// HEX      | present digest nibbles MSB first until 16 are accepted
// FIN      | done pulse
module hash_msg_streamer
  import hash_msg_streamer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int GAP_W = GAP_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  input  logic [7:0]       wr_data,
  output logic             wr_ready,
  input  logic             start,
  input  logic [63:0]      c_init,
  input  logic [GAP_W-1:0] gap,
  output logic             busy,
  output logic             M_valid,
  output logic [7:0]       M,
  output logic [63:0]      C_in,
  input  logic             hash_ready,
  input  logic [63:0]      digest_out,
  output logic             hex_valid,
  output logic [7:0]       hex_char,
  input  logic             hex_ready,
  output logic             done
);

  localparam int AW = $clog2(DEPTH);

  state_t           state_q, state_d;
  logic             ready_en_q;
  logic [63:0]      c_q;
  logic [7:0]       m_q;
  logic [GAP_W-1:0] gap_ld_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic [63:0]      dig_q;
  logic [3:0]       nib_cnt_q;

  logic             pop, take_start, take_dig, hex_adv;
  logic [7:0]       fifo_rd;
  logic             fifo_full, fifo_empty;
  logic [AW:0]      fifo_count;

  hash_msg_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_valid && wr_ready),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    take_start = 1'b0;
    take_dig   = 1'b0;
    hex_adv    = 1'b0;
    wr_ready   = 1'b0;
    busy       = (state_q != IDLE);
    M_valid    = 1'b0;
    M          = m_q;
    C_in       = c_q;
    hex_valid  = 1'b0;
    hex_char   = 8'h00;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        wr_ready = ready_en_q && !fifo_full;
        if (start && !fifo_empty) begin
          take_start = 1'b1;
          state_d    = SEND;
        end
      end
      SEND: begin
        pop     = 1'b1;
        M_valid = 1'b1;
        M       = fifo_rd;
        // count still includes the byte being popped
        state_d = (fifo_count > (AW+1)'(1)) ? GAP : WAIT_DIG;
      end
      GAP: begin
        if (gap_cnt_q <= GAP_W'(1)) state_d = SEND;
      end
      WAIT_DIG: begin
        if (hash_ready) begin
          take_dig = 1'b1;
          state_d  = HEX;
        end
      end
      HEX: begin
        hex_valid = 1'b1;
        hex_char  = nib2asc(dig_q[63:60]);
        if (hex_ready) begin
          hex_adv = 1'b1;
          if (nib_cnt_q == 4'hf) state_d = FIN;
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q <= 1'b0;
      c_q        <= '0;
      m_q        <= '0;
      gap_ld_q   <= GAP_W'(1);
      gap_cnt_q  <= '0;
      dig_q      <= '0;
      nib_cnt_q  <= '0;
    end else begin
      // keeps wr_ready low until the first clock after reset release
      ready_en_q <= 1'b1;
      if (take_start) begin
        c_q      <= c_init;
        gap_ld_q <= (gap == '0) ? GAP_W'(1) : gap;
      end
      if (pop) begin
        m_q       <= fifo_rd;
        gap_cnt_q <= gap_ld_q;
      end else if (state_q == GAP) begin
        gap_cnt_q <= gap_cnt_q - 1'b1;
      end
      if (take_dig) begin
        dig_q     <= digest_out;
        nib_cnt_q <= '0;
      end else if (hex_adv) begin
        dig_q     <= {dig_q[59:0], 4'h0};
        nib_cnt_q <= nib_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hash_msg_streamer.sv
module tb_hash_msg_streamer;

  localparam int DEPTH = 16;
  localparam int GAP_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wr_valid;
  logic [7:0]       wr_data;
  logic             wr_ready;
  logic             start;
  logic [63:0]      c_init;
  logic [GAP_W-1:0] gap;
  logic             busy;
  logic             M_valid;
  logic [7:0]       M;
  logic [63:0]      C_in;
  logic             hash_ready;
  logic [63:0]      digest_out;
  logic             hex_valid;
  logic [7:0]       hex_char;
  logic             hex_ready;
  logic             done;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] wq[$];
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  hash_msg_streamer #(.DEPTH(DEPTH), .GAP_W(GAP_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .start      (start),
    .c_init     (c_init),
    .gap        (gap),
    .busy       (busy),
    .M_valid    (M_valid),
    .M          (M),
    .C_in       (C_in),
    .hash_ready (hash_ready),
    .digest_out (digest_out),
    .hex_valid  (hex_valid),
    .hex_char   (hex_char),
    .hex_ready  (hex_ready),
    .done       (done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_M_valid"},   64'(M_valid),   64'd0);
    chk({tag, "_M"},         64'(M),         64'd0);
    chk({tag, "_C_in"},      C_in,           64'd0);
    chk({tag, "_hex_valid"}, 64'(hex_valid), 64'd0);
    chk({tag, "_hex_char"},  64'(hex_char),  64'd0);
    chk({tag, "_done"},      64'(done),      64'd0);
    chk({tag, "_busy"},      64'(busy),      64'd0);
    chk({tag, "_wr_ready"},  64'(wr_ready),  64'd0);
  endtask

  // Writes wq into the empty buffer; only the first DEPTH bytes may be taken.
  task automatic write_bytes();
    int acc = 0;
    foreach (wq[i]) begin
      @(negedge clk);
      wr_data  = wq[i];
      wr_valid = 1'b1;
      chk("wr_ready", 64'(wr_ready), 64'(acc < DEPTH));
      if (acc < DEPTH) begin
        exp_q.push_back(wq[i]);
        acc++;
      end
    end
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic start_empty_check(input string tag);
    bit seen = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) begin
      if (busy) seen = 1;
      @(negedge clk);
    end
    chk(tag, 64'(seen), 64'd0);
  endtask

  task automatic run_msg(input logic [63:0] ci, input logic [GAP_W-1:0] gp,
                         input logic [63:0] dig, input string hx,
                         input bit rnd, input bit poke);
    int n = exp_q.size();
    int geff = (gp == 0) ? 1 : int'(gp);
    int stamp[$];
    logic [7:0] got[$];
    logic [7:0] last_m = 8'h00;
    logic [7:0] prev_char = 8'h00;
    int cyc = 0, last = -1, hidx = 0, first_hex = -1, last_acc = -1, done_cyc = -1;
    bit hold_ok = 1, cin_ok = 1, stall_ok = 1, prev_stall = 0, done_seen = 0;
    bit hrdy;
    digest_out = dig;
    hash_ready = 1'b0;
    @(negedge clk);
    start  = 1'b1;
    c_init = ci;
    gap    = gp;
    @(negedge clk);
    start = 1'b0;
    chk("busy_on", 64'(busy), 64'd1);
    while (!done_seen && cyc < 2000) begin
      if (M_valid) begin
        if (got.size() < 64) begin
          got.push_back(M);
          stamp.push_back(cyc);
        end
        last   = cyc;
        last_m = M;
      end else if (got.size() > 0 && M !== last_m) begin
        hold_ok = 0;
      end
      if (C_in !== ci) cin_ok = 0;
      if (done) begin
        done_seen = 1;
        done_cyc  = cyc;
      end
      hash_ready = (last >= 0 && got.size() == n && cyc >= last + 7);
      if (prev_stall && (!hex_valid || hex_char !== prev_char)) stall_ok = 0;
      hrdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      hex_ready = hrdy;
      prev_stall = 0;
      if (hex_valid) begin
        if (first_hex < 0) first_hex = cyc;
        if (hrdy) begin
          if (hidx < 16) chk("hex_digit", 64'(hex_char), 64'(hx[hidx]));
          else chk("hex_extra", 64'(hidx), 64'd15);
          hidx++;
          last_acc = cyc;
        end else begin
          prev_stall = 1;
          prev_char  = hex_char;
        end
      end
      if (poke && cyc == 3) begin
        wr_valid = 1'b1;
        wr_data  = 8'hEE;
        start    = 1'b1;
      end else begin
        wr_valid = 1'b0;
        start    = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    hash_ready = 1'b0;
    hex_ready  = 1'b0;
    chk("done_seen", 64'(done_seen), 64'd1);
    chk("n_strobes", 64'(got.size()), 64'(n));
    for (int i = 0; i < n && i < got.size(); i++) chk("byte", 64'(got[i]), 64'(exp_q[i]));
    for (int i = 0; i + 1 < stamp.size(); i++)
      chk("spacing", 64'(stamp[i+1] - stamp[i]), 64'(geff + 1));
    chk("m_hold", 64'(hold_ok), 64'd1);
    chk("c_in_hold", 64'(cin_ok), 64'd1);
    chk("hex_stall_stable", 64'(stall_ok), 64'd1);
    chk("hex_count", 64'(hidx), 64'd16);
    chk("first_hex_lat", 64'(first_hex - last), 64'd8);
    if (!rnd) chk("hex_consecutive", 64'(last_acc - first_hex), 64'd15);
    chk("done_after_last", 64'(done_cyc - last_acc), 64'd1);
    chk("done_pulse_end", 64'(done), 64'd0);
    chk("busy_off", 64'(busy), 64'd0);
    chk("c_in_after", C_in, ci);
    exp_q.delete();
  endtask

  initial begin
    int cnt;
    rst_n      = 1'b0;
    wr_valid   = 1'b0;
    wr_data    = 8'h00;
    start      = 1'b0;
    c_init     = '0;
    gap        = '0;
    hash_ready = 1'b0;
    digest_out = '0;
    hex_ready  = 1'b0;
    #3;
    check_reset("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // "Hello", gap 0 behaves as gap 1
    wq = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    write_bytes();
    run_msg(64'd5, 3'd0, 64'h0123456789abcdef, "0123456789abcdef", 0, 0);

    // "Hi", gap 4, random hex_ready, write+start poked while busy
    wq = '{8'h48, 8'h69};
    write_bytes();
    run_msg(64'hdeadbeef00c0ffee, 3'd4, 64'h0123456789abcdef, "0123456789abcdef", 1, 1);
    start_empty_check("poke_left_buffer_empty");

    // 17 bytes into a 16-deep buffer, pointers wrap
    wq.delete();
    for (int i = 0; i < 17; i++) wq.push_back(8'(8'h41 + i));
    write_bytes();
    run_msg(64'h1, 3'd1, 64'hfedcba9876543210, "fedcba9876543210", 0, 0);
    start_empty_check("empty_start_busy");

    // reset during the gap after the 3rd byte
    wq = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
    write_bytes();
    exp_q.delete();
    @(negedge clk);
    start  = 1'b1;
    c_init = 64'd77;
    gap    = 3'd3;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    for (int t = 0; t < 100; t++) begin
      if (M_valid) cnt++;
      if (cnt == 3) break;
      @(negedge clk);
    end
    chk("rst_third_strobe", 64'(cnt), 64'd3);
    @(negedge clk);
    chk("rst_in_gap", 64'(M_valid), 64'd0);
    rst_n = 1'b0;
    #1;
    check_reset("mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (40) begin
      if (M_valid || busy) cnt++;
      @(negedge clk);
    end
    chk("no_strobes_after_rst", 64'(cnt), 64'd0);
    start_empty_check("rst_discarded_buffer");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
